regfile_scoreboard: RTL and testbench

- Parametrised successor to the 16x32 register bank.
- Two registered read ports, one write port; depth and width set by parameters.
- Adds active-low asynchronous reset, write-to-read bypass and an optional hardwired-zero register 0.
- Adds a per-register busy scoreboard so the issue stage can detect a read of a register whose pending write has not yet landed.
- Sits between decode/issue (read, reserve) and writeback (write) in the RISC pipeline.

---
 rtl/regfile_pkg.sv | 7 +
 rtl/regfile_read_port.sv | 58 +++++
 rtl/regfile_scoreboard.sv | 83 ++++++++
 tb/tb_regfile_scoreboard.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults for the parametrised register file and its read ports.
package regfile_pkg;
  localparam int unsigned DEF_WIDTH      = 32;
  localparam int unsigned DEF_ADDR_WIDTH = 4;
  localparam int unsigned DEF_NUM_REGS   = 16;
  localparam int unsigned ZERO_IDX       = 0;
endpackage

// File: rtl/regfile_read_port.sv
// One registered read port: range check, zero-register masking, write-first bypass.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned NUM_REGS   = DEF_NUM_REGS,
  parameter bit          ZERO_REG   = 1'b1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               rd_en,
  input  logic [ADDR_WIDTH-1:0]              rd_addr,
  input  logic [NUM_REGS-1:0][WIDTH-1:0]     regs,
  input  logic [NUM_REGS-1:0]                busy_next,
  input  logic                               wr_ok,
  input  logic [ADDR_WIDTH-1:0]              wr_addr,
  input  logic [WIDTH-1:0]                   wr_data,
  output logic [WIDTH-1:0]                   rd_data,
  output logic                               rd_valid,
  output logic                               rd_busy
);

  logic [31:0]      rd_idx;
  logic [WIDTH-1:0] data_d;
  logic             busy_d;

  assign rd_idx = 32'(rd_addr);

  // Out-of-range and zero-register reads fall through to data 0, busy 0.
  // wr_ok already excludes those addresses, so the bypass cannot revive them.
  always_comb begin
    data_d = '0;
    busy_d = 1'b0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (rd_idx == i && !(ZERO_REG && i == ZERO_IDX)) begin
        data_d = regs[i];
        busy_d = busy_next[i];
      end
    end
    if (wr_ok && wr_addr == rd_addr) data_d = wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_busy  <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= data_d;
        rd_busy <= busy_d;
      end
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Two-read/one-write register file with a per-register busy scoreboard for issue-stage hazard checks.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned      WIDTH      = DEF_WIDTH,
  parameter int unsigned      ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned      NUM_REGS   = DEF_NUM_REGS,
  parameter bit               ZERO_REG   = 1'b1,
  parameter logic [WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_en1,
  input  logic [ADDR_WIDTH-1:0] rd_addr1,
  input  logic                  rd_en2,
  input  logic [ADDR_WIDTH-1:0] rd_addr2,
  output logic [WIDTH-1:0]      rd_data1,
  output logic [WIDTH-1:0]      rd_data2,
  output logic                  rd_valid1,
  output logic                  rd_valid2,
  output logic                  rd_busy1,
  output logic                  rd_busy2,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rsv_en,
  input  logic [ADDR_WIDTH-1:0] rsv_addr,
  output logic [NUM_REGS-1:0]   busy_vec
);

  logic [NUM_REGS-1:0][WIDTH-1:0] regs;
  logic [NUM_REGS-1:0]            busy;
  logic [NUM_REGS-1:0]            busy_next;
  logic [31:0]                    wr_idx;
  logic [31:0]                    rsv_idx;
  logic                           wr_ok;
  logic                           rsv_ok;

  assign wr_idx  = 32'(wr_addr);
  assign rsv_idx = 32'(rsv_addr);
  assign wr_ok   = wr_en  && wr_idx  < NUM_REGS && !(ZERO_REG && wr_idx  == ZERO_IDX);
  assign rsv_ok  = rsv_en && rsv_idx < NUM_REGS && !(ZERO_REG && rsv_idx == ZERO_IDX);

  // Set after clear: a reservation landing with a write to the same register wins.
  always_comb begin
    busy_next = busy;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (wr_ok && wr_idx == i)   busy_next[i] = 1'b0;
      if (rsv_ok && rsv_idx == i) busy_next[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs <= {NUM_REGS{RESET_VAL}};
      busy <= '0;
    end else begin
      busy <= busy_next;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (wr_ok && wr_idx == i) regs[i] <= wr_data;
      end
    end
  end

  assign busy_vec = busy;

  regfile_read_port #(
    .WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .NUM_REGS(NUM_REGS), .ZERO_REG(ZERO_REG)
  ) u_port1 (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en1), .rd_addr(rd_addr1),
    .regs(regs), .busy_next(busy_next), .wr_ok(wr_ok), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_data(rd_data1), .rd_valid(rd_valid1), .rd_busy(rd_busy1)
  );

  regfile_read_port #(
    .WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .NUM_REGS(NUM_REGS), .ZERO_REG(ZERO_REG)
  ) u_port2 (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en2), .rd_addr(rd_addr2),
    .regs(regs), .busy_next(busy_next), .wr_ok(wr_ok), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_data(rd_data2), .rd_valid(rd_valid2), .rd_busy(rd_busy2)
  );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Table-driven bench for regfile_scoreboard with an expected-result queue and reset corner sequences.
module tb_regfile_scoreboard;

  logic        clk;
  logic        rst_n;
  logic        rd_en1, rd_en2, wr_en, rsv_en;
  logic [3:0]  rd_addr1, rd_addr2, wr_addr, rsv_addr;
  logic [31:0] wr_data, rd_data1, rd_data2;
  logic        rd_valid1, rd_valid2, rd_busy1, rd_busy2;
  logic [15:0] busy_vec;

  regfile_scoreboard #(
    .WIDTH(32), .ADDR_WIDTH(4), .NUM_REGS(16), .ZERO_REG(1'b1), .RESET_VAL(32'h1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_en1(rd_en1), .rd_addr1(rd_addr1), .rd_en2(rd_en2), .rd_addr2(rd_addr2),
    .rd_data1(rd_data1), .rd_data2(rd_data2), .rd_valid1(rd_valid1), .rd_valid2(rd_valid2),
    .rd_busy1(rd_busy1), .rd_busy2(rd_busy2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_vec(busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;  logic [3:0] wa; logic [31:0] wd;
    logic        re;  logic [3:0] ra;
    logic        r1;  logic [3:0] a1;
    logic        r2;  logic [3:0] a2;
    logic [31:0] d1;  logic b1;
    logic [31:0] d2;  logic b2;
    logic [15:0] bv;
  } vec_t;

  typedef struct {
    int          id;
    logic        v1; logic [31:0] d1; logic b1;
    logic        v2; logic [31:0] d2; logic b2;
    logic [15:0] bv;
  } exp_t;

  exp_t        exp_q[$];
  vec_t        tbl[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] last_d1 = '0, last_d2 = '0;
  logic        last_b1 = 1'b0, last_b2 = 1'b0;

  task automatic chk(input string nm, input int id, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s[%0d] actual=%h required=%h", nm, id, act, req);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                              input logic re, input logic [3:0] ra,
                              input logic r1, input logic [3:0] a1, input logic [31:0] d1, input logic b1,
                              input logic r2, input logic [3:0] a2, input logic [31:0] d2, input logic b2,
                              input logic [15:0] bv);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.re = re; v.ra = ra;
    v.r1 = r1; v.a1 = a1; v.d1 = d1; v.b1 = b1;
    v.r2 = r2; v.a2 = a2; v.d2 = d2; v.b2 = b2; v.bv = bv;
    return v;
  endfunction

  task automatic idle_inputs();
    wr_en = 0; wr_addr = '0; wr_data = '0; rsv_en = 0; rsv_addr = '0;
    rd_en1 = 0; rd_addr1 = '0; rd_en2 = 0; rd_addr2 = '0;
  endtask

  // Drive at a negedge, queue the expectation, compare at the following negedge.
  task automatic apply(input vec_t v, input int id);
    exp_t e;
    exp_t got;
    wr_en = v.we; wr_addr = v.wa; wr_data = v.wd; rsv_en = v.re; rsv_addr = v.ra;
    rd_en1 = v.r1; rd_addr1 = v.a1; rd_en2 = v.r2; rd_addr2 = v.a2;
    e.id = id; e.bv = v.bv;
    e.v1 = v.r1; e.d1 = v.r1 ? v.d1 : last_d1; e.b1 = v.r1 ? v.b1 : last_b1;
    e.v2 = v.r2; e.d2 = v.r2 ? v.d2 : last_d2; e.b2 = v.r2 ? v.b2 : last_b2;
    last_d1 = e.d1; last_b1 = e.b1; last_d2 = e.d2; last_b2 = e.b2;
    exp_q.push_back(e);
    @(negedge clk);
    got = exp_q.pop_front();
    chk("rd_valid1", got.id, 64'(rd_valid1), 64'(got.v1));
    chk("rd_data1",  got.id, 64'(rd_data1),  64'(got.d1));
    chk("rd_busy1",  got.id, 64'(rd_busy1),  64'(got.b1));
    chk("rd_valid2", got.id, 64'(rd_valid2), 64'(got.v2));
    chk("rd_data2",  got.id, 64'(rd_data2),  64'(got.d2));
    chk("rd_busy2",  got.id, 64'(rd_busy2),  64'(got.b2));
    chk("busy_vec",  got.id, 64'(busy_vec),  64'(got.bv));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    #12;
    chk("reset_valid1", 0, 64'(rd_valid1), 64'd0);
    chk("reset_data2",  0, 64'(rd_data2),  64'd0);
    chk("reset_busyv",  0, 64'(busy_vec),  64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset contents: register 0 reads 0, all others RESET_VAL = 1.
    for (int i = 0; i < 16; i++) begin
      apply(mk(0, 4'd0, 32'h0, 0, 4'd0,
               1, 4'(i), (i == 0) ? 32'h0 : 32'h1, 0,
               1, 4'(i), (i == 0) ? 32'h0 : 32'h1, 0, 16'h0), 100 + i);
    end

    //            we wa     wd            re ra     r1 a1     d1            b1 r2 a2     d2            b2 bv
    tbl.push_back(mk(1, 4'd5, 32'hDEADBEEF, 0, 4'd0, 0, 4'd0, 32'h0,        0, 0, 4'd0, 32'h0,        0, 16'h0000));
    tbl.push_back(mk(0, 4'd0, 32'h0,        0, 4'd0, 1, 4'd5, 32'hDEADBEEF, 0, 0, 4'd0, 32'h0,        0, 16'h0000));
    tbl.push_back(mk(1, 4'd3, 32'h12345678, 0, 4'd0, 1, 4'd3, 32'h12345678, 0, 1, 4'd3, 32'h12345678, 0, 16'h0000));
    tbl.push_back(mk(0, 4'd0, 32'h0,        1, 4'd7, 0, 4'd0, 32'h0,        0, 0, 4'd0, 32'h0,        0, 16'h0080));
    tbl.push_back(mk(0, 4'd0, 32'h0,        0, 4'd0, 1, 4'd5, 32'hDEADBEEF, 0, 1, 4'd7, 32'h1,        1, 16'h0080));
    tbl.push_back(mk(1, 4'd7, 32'hA5,       0, 4'd0, 1, 4'd7, 32'hA5,       0, 0, 4'd0, 32'h0,        0, 16'h0000));
    tbl.push_back(mk(0, 4'd0, 32'h0,        0, 4'd0, 1, 4'd7, 32'hA5,       0, 1, 4'd7, 32'hA5,       0, 16'h0000));
    tbl.push_back(mk(1, 4'd7, 32'h77,       1, 4'd7, 1, 4'd7, 32'h77,       1, 0, 4'd0, 32'h0,        0, 16'h0080));
    tbl.push_back(mk(0, 4'd0, 32'h0,        0, 4'd0, 0, 4'd0, 32'h0,        0, 1, 4'd7, 32'h77,       1, 16'h0080));
    tbl.push_back(mk(1, 4'd0, 32'hFFFFFFFF, 1, 4'd0, 1, 4'd0, 32'h0,        0, 0, 4'd0, 32'h0,        0, 16'h0080));
    tbl.push_back(mk(0, 4'd0, 32'h0,        0, 4'd0, 1, 4'd0, 32'h0,        0, 1, 4'd0, 32'h0,        0, 16'h0080));
    tbl.push_back(mk(1, 4'd7, 32'h1234,     1, 4'd9, 1, 4'd9, 32'h1,        1, 1, 4'd3, 32'h12345678, 0, 16'h0200));
    tbl.push_back(mk(0, 4'd0, 32'h0,        0, 4'd0, 0, 4'd0, 32'h0,        0, 0, 4'd0, 32'h0,        0, 16'h0200));
    tbl.push_back(mk(1, 4'd9, 32'hCAFE,     0, 4'd0, 1, 4'd9, 32'hCAFE,     0, 1, 4'd7, 32'h1234,     0, 16'h0000));
    tbl.push_back(mk(1, 4'd2, 32'h55,       1, 4'd4, 1, 4'd4, 32'h1,        1, 1, 4'd4, 32'h1,        1, 16'h0010));
    foreach (tbl[k]) apply(tbl[k], k);

    // Asynchronous reset between edges discards reservations, writes and read results.
    wr_en = 1; wr_addr = 4'd2; wr_data = 32'h66; rsv_en = 1; rsv_addr = 4'd9;
    rd_en1 = 1; rd_addr1 = 4'd2; rd_en2 = 0;
    @(posedge clk);
    #1;
    chk("pre_rst_data1", 300, 64'(rd_data1), 64'h66);
    chk("pre_rst_busyv", 300, 64'(busy_vec), 64'h0210);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_valid1", 301, 64'(rd_valid1), 64'd0);
    chk("async_data1",  301, 64'(rd_data1),  64'd0);
    chk("async_busy2",  301, 64'(rd_busy2),  64'd0);
    chk("async_busyv",  301, 64'(busy_vec),  64'd0);
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    last_d1 = '0; last_d2 = '0; last_b1 = 1'b0; last_b2 = 1'b0;
    apply(mk(0, 4'd0, 32'h0, 0, 4'd0, 1, 4'd2, 32'h1, 0, 1, 4'd9, 32'h1, 0, 16'h0000), 400);
    apply(mk(0, 4'd0, 32'h0, 0, 4'd0, 0, 4'd0, 32'h0, 0, 1, 4'd4, 32'h1, 0, 16'h0000), 401);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
